debug_command_unit: RTL and testbench
=====================================

// Module: debug_command_unit
// PURPOSE
//  Sits between the UART RX/TX FIFOs and the 5-stage pipeline core. Pops command bytes from
//  the RX FIFO, controls the pipeline clock-enable (run / halt / single-step), and streams a
//  latched snapshot of pipeline state (register file, stage latches, PC) out through the TX
//  FIFO as a framed, checksummed byte stream.
// PARAMETERS
//  NUM_WORDS   40      number of 32-bit words in snapshot (32 GPRs + 8 stage/debug words)
//  CMD_RUN     8'h63   'c': continuous run
//  CMD_HALT    8'h68   'h': halt
//  CMD_STEP    8'h73   's': advance pipeline exactly one cycle (only when halted)
//  CMD_DUMP    8'h64   'd': send snapshot frame
//  HEADER      8'hA5   first byte of every dump frame
// PORTS
//  clock        in   1              system clock; all logic on rising edge
//  reset_n      in   1              asynchronous, active-low reset
//  rx_empty     in   1              RX FIFO empty
//  rx_data      in   8              RX FIFO head byte, valid while rx_empty=0
//  rd_uart      out  1              pop RX FIFO head (one byte per asserted cycle)
//  tx_full      in   1              TX FIFO full
//  wr_uart      out  1              push tx_data into TX FIFO
//  tx_data      out  8              byte to transmit
//  snapshot     in   NUM_WORDS*32   flattened pipeline state; word i = snapshot[i*32 +: 32]
//  pipe_enable  out  1              clock-enable to all pipeline stage registers (registered)
//  running      out  1              1 = continuous-run mode
//  busy         out  1              1 while a dump frame is being sent
//  cycle_count  out  32             number of cycles pipe_enable was 1 since reset
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; rd_uart, wr_uart, pipe_enable, running, busy = 0;
//   tx_data=8'h00; cycle_count=0; checksum and byte index cleared. Applies mid-dump: frame aborted.
//  FSM states: IDLE, STEP, HDR, PAYLOAD, CSUM.
//  IDLE: if rx_empty=0 -> rd_uart=1 (combinational, same cycle), rx_data decoded that cycle:
//   CMD_RUN  -> running<=1, stay IDLE.      CMD_HALT -> running<=0, stay IDLE.
//   CMD_STEP -> if running=0 go STEP, else ignored (byte still popped).
//   CMD_DUMP -> latch snapshot into internal copy, busy<=1, go HDR.
//   any other byte -> popped and discarded, no other effect.
//  rd_uart is 0 in every state except IDLE; bytes arriving during STEP/dump wait in the FIFO.
//  STEP: lasts exactly 1 cycle, returns to IDLE. pipe_enable registered:
//   pipe_enable <= (running_next | (state_next==STEP)) & ~busy_next. A step therefore produces
//   exactly one pipe_enable=1 cycle, the cycle after the pop edge + 1.
//  Pipeline is frozen (pipe_enable=0) while busy=1; resumes next cycle after CSUM if running.
//  HDR: wr_uart=!tx_full, tx_data=HEADER; advance to PAYLOAD on accepted cycle (wr_uart=1).
//  PAYLOAD: byte index k = 0..NUM_WORDS*4-1; word i=k/4, byte j=k%4, big-endian per word:
//   tx_data = latched[i*32 + (3-j)*8 +: 8]. wr_uart=!tx_full; k and checksum (XOR of payload
//   bytes, header excluded) update only on accepted cycles. After last byte -> CSUM.
//  CSUM: send checksum byte with same tx_full rule; on accept busy<=0, k<=0, checksum<=0, IDLE.
//  tx_full=1 stalls any send state indefinitely with wr_uart=0; no byte dropped or duplicated.
//  Frame length = 1 + 4*NUM_WORDS + 1 bytes (162 at default). Min latency pop->last byte =
//   frame length cycles with tx_full=0.
//  cycle_count increments when pipe_enable=1, wraps 32'hFFFFFFFF -> 0.
//  Snapshot changes after latch do not affect an in-flight frame.
// STRUCTURE
//  debug_pkg: command byte constants, HEADER, FSM state enum (3-bit encoding), word/byte widths.
//  Sub-module debug_tx_serializer: HDR/PAYLOAD/CSUM sequencing, byte index, byte mux, XOR
//   checksum, tx_full handshake; top holds command decode, run/step control, cycle_count.
// TESTING
//  1 Reset: hold reset_n=0 then release -> all outputs 0, cycle_count=0, no rd_uart while rx_empty=1.
//  2 Push 'c', wait 10 cycles, push 'h' -> running 1 then 0; cycle_count advances by 10+/-1
//    exactly matching count of pipe_enable=1 cycles; unknown byte 8'h41 popped, no effect.
//  3 Halted, push 's' three times -> exactly 3 single-cycle pipe_enable pulses, cycle_count=3;
//    's' while running -> no extra pulse.
//  4 Snapshot word0=32'h11223344, others 0, push 'd', tx_full=0 -> bytes A5,11,22,33,44,0x00*156,
//    checksum 8'h44; total 162 wr_uart pulses; pipe_enable=0 throughout, busy high for frame.
//  5 Same dump with tx_full toggled randomly and snapshot changed mid-frame -> identical byte
//    sequence to scenario 4; 'c' queued during dump is popped only after CSUM.
//  6 Assert reset_n=0 at payload byte 50 -> outputs reset immediately; next 'd' sends full fresh frame.

Source files
------------

// File: rtl/debug_command_unit_pkg.sv
// Shared constants and FSM encoding for the debug command unit.
package debug_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    localparam logic [BYTE_W-1:0] CMD_RUN  = 8'h63;
    localparam logic [BYTE_W-1:0] CMD_HALT = 8'h68;
    localparam logic [BYTE_W-1:0] CMD_STEP = 8'h73;
    localparam logic [BYTE_W-1:0] CMD_DUMP = 8'h64;
    localparam logic [BYTE_W-1:0] HEADER   = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_STEP    = 3'd1,
        ST_HDR     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CSUM    = 3'd4
    } state_e;

endpackage

// File: rtl/debug_command_unit_tx_serializer.sv
// Sends one dump frame: header, big-endian snapshot words, XOR checksum of the payload.
module debug_tx_serializer
    import debug_pkg::*;
#(
    parameter int NUM_WORDS = 40
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    input  logic [NUM_WORDS*WORD_W-1:0] snapshot_i,
    input  logic                        tx_full_i,
    output logic                        wr_o,
    output logic [BYTE_W-1:0]           data_o,
    output logic                        busy_o,
    output logic                        busy_next_o
);

    localparam int NB = NUM_WORDS * (WORD_W / BYTE_W);
    localparam int KW = $clog2(NB);

    state_e            state_q;
    logic [KW-1:0]     k_q;
    logic [BYTE_W-1:0] csum_q;
    logic              busy_q;
    logic [BYTE_W-1:0] bytes_q [NB];
    logic [KW-1:0]     sel;

    // Byte j of a word goes out MSB first, so the flat byte address flips the low two bits.
    assign sel = {k_q[KW-1:2], ~k_q[1:0]};

    always_comb begin
        wr_o   = 1'b0;
        data_o = '0;
        case (state_q)
            ST_HDR: begin
                wr_o   = ~tx_full_i;
                data_o = HEADER;
            end
            ST_PAYLOAD: begin
                wr_o   = ~tx_full_i;
                data_o = bytes_q[sel];
            end
            ST_CSUM: begin
                wr_o   = ~tx_full_i;
                data_o = csum_q;
            end
            default: ;
        endcase
    end

    assign busy_o      = busy_q;
    assign busy_next_o = start_i | (busy_q & ~((state_q == ST_CSUM) & wr_o));

    always_ff @(posedge clk_i) begin
        if (start_i) begin
            for (int b = 0; b < NB; b++) begin
                bytes_q[b] <= snapshot_i[b*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            csum_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_HDR;
                        busy_q  <= 1'b1;
                    end
                end
                ST_HDR: begin
                    if (wr_o) state_q <= ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    if (wr_o) begin
                        csum_q <= csum_q ^ data_o;
                        if (k_q == KW'(NB - 1)) begin
                            k_q     <= '0;
                            state_q <= ST_CSUM;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                ST_CSUM: begin
                    if (wr_o) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        csum_q  <= '0;
                        k_q     <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/debug_command_unit.sv
// Debug command front end: decodes RX command bytes, gates the pipeline clock-enable,
// counts enabled cycles and hands dump requests to the TX serializer.
module debug_command_unit
    import debug_pkg::*;
#(
    parameter int NUM_WORDS = 40
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        rx_empty,
    input  logic [BYTE_W-1:0]           rx_data,
    output logic                        rd_uart,
    input  logic                        tx_full,
    output logic                        wr_uart,
    output logic [BYTE_W-1:0]           tx_data,
    input  logic [NUM_WORDS*WORD_W-1:0] snapshot,
    output logic                        pipe_enable,
    output logic                        running,
    output logic                        busy,
    output logic [31:0]                 cycle_count
);

    state_e      ctrl_q, ctrl_d;
    logic        running_q, running_d;
    logic        pipe_en_q;
    logic [31:0] cnt_q;
    logic        dump_start;
    logic        ser_busy, ser_busy_next;

    // Commands are only taken while idle and no frame is in flight; later bytes wait in the FIFO.
    always_comb begin
        ctrl_d     = ST_IDLE;
        running_d  = running_q;
        dump_start = 1'b0;
        rd_uart    = 1'b0;
        if (ctrl_q == ST_IDLE && !ser_busy && !rx_empty) begin
            rd_uart = 1'b1;
            case (rx_data)
                CMD_RUN:  running_d = 1'b1;
                CMD_HALT: running_d = 1'b0;
                CMD_STEP: if (!running_q) ctrl_d = ST_STEP;
                CMD_DUMP: dump_start = 1'b1;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q    <= ST_IDLE;
            running_q <= 1'b0;
            pipe_en_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            running_q <= running_d;
            pipe_en_q <= (running_d | (ctrl_d == ST_STEP)) & ~ser_busy_next;
            if (pipe_en_q) cnt_q <= cnt_q + 32'd1;
        end
    end

    debug_tx_serializer #(
        .NUM_WORDS (NUM_WORDS)
    ) u_ser (
        .clk_i       (clock),
        .rst_ni      (reset_n),
        .start_i     (dump_start),
        .snapshot_i  (snapshot),
        .tx_full_i   (tx_full),
        .wr_o        (wr_uart),
        .data_o      (tx_data),
        .busy_o      (ser_busy),
        .busy_next_o (ser_busy_next)
    );

    assign pipe_enable = pipe_en_q;
    assign running     = running_q;
    assign busy        = ser_busy;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_debug_command_unit.sv
// Scoreboard bench: stimulus queues expected frames, a monitor checks TX bytes and invariants.
module tb_debug_command_unit;

    localparam int NW    = 40;
    localparam int FRAME = 4 * NW + 2;
    localparam logic [7:0] C_RUN = 8'h63, C_HALT = 8'h68, C_STEP = 8'h73, C_DUMP = 8'h64;

    logic clock = 1'b0, reset_n = 1'b0, rx_empty = 1'b1, tx_full = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic rd_uart, wr_uart, pipe_enable, running, busy;
    logic [7:0] tx_data;
    logic [31:0] cycle_count;
    logic [NW*32-1:0] snapshot = '0;

    int checks = 0, errors = 0;
    logic [7:0] rxq[$];
    logic [7:0] expq[$];
    int wr_total = 0, busy_total = 0, pe_hist = 0, pe_mark = 0;
    bit full_rand = 0, pop_pend = 0, mark = 0;

    always #5 clock = ~clock;

    debug_command_unit #(.NUM_WORDS(NW)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .rx_empty    (rx_empty),
        .rx_data     (rx_data),
        .rd_uart     (rd_uart),
        .tx_full     (tx_full),
        .wr_uart     (wr_uart),
        .tx_data     (tx_data),
        .snapshot    (snapshot),
        .pipe_enable (pipe_enable),
        .running     (running),
        .busy        (busy),
        .cycle_count (cycle_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected bytes on every accepted TX write and checks cycle-level rules.
    always @(negedge clock) begin
        logic [7:0] e;
        if (!reset_n) begin
            pe_hist = 0;
        end else begin
            check("cycle_count", cycle_count, pe_hist);
            if (pipe_enable) pe_hist++;
            if (busy) busy_total++;
            check("pe_while_busy", {31'b0, pipe_enable & busy}, 32'd0);
            check("rd_bad", {31'b0, rd_uart & (rx_empty | busy)}, 32'd0);
            check("wr_when_full", {31'b0, wr_uart & tx_full}, 32'd0);
            if (wr_uart) begin
                wr_total++;
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_byte: got unexpected %02h expected no byte", tx_data);
                end else begin
                    e = expq.pop_front();
                    check("tx_byte", {24'b0, tx_data}, {24'b0, e});
                end
            end
        end
    end

    task automatic rx_refresh();
        rx_empty = (rxq.size() == 0);
        rx_data  = rx_empty ? 8'h00 : rxq[0];
    endtask

    task automatic push(input logic [7:0] b);
        rxq.push_back(b);
        rx_refresh();
    endtask

    task automatic tick();
        @(negedge clock);
        pop_pend = rd_uart && reset_n;
        if (pop_pend && rxq.size() > 0 && rxq[0] == C_STEP) mark = 1;
        if (mark && pipe_enable) pe_mark++;
        @(posedge clock);
        #1;
        if (pop_pend && rxq.size() > 0) void'(rxq.pop_front());
        rx_refresh();
        tx_full = full_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
    endtask

    task automatic settle(input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while ((rxq.size() != 0 || busy) && n < budget);
        if (rxq.size() != 0 || busy) begin
            checks++;
            errors++;
            $display("FAIL settle_timeout: got busy=%0b rxq=%0d expected idle", busy, rxq.size());
        end
        repeat (2) tick();
    endtask

    // Reference frame: header, each word MSB first, XOR of payload bytes.
    task automatic build_frame(input logic [NW*32-1:0] snap);
        logic [7:0] cs = 8'h00;
        logic [7:0] b;
        logic [31:0] word;
        expq.push_back(8'hA5);
        for (int w = 0; w < NW; w++) begin
            word = snap[w*32 +: 32];
            for (int j = 0; j < 4; j++) begin
                b = 8'(word >> (24 - 8 * j));
                expq.push_back(b);
                cs ^= b;
            end
        end
        expq.push_back(cs);
    endtask

    task automatic rand_snapshot();
        for (int w = 0; w < NW; w++) snapshot[w*32 +: 32] = $urandom();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd"}, {31'b0, rd_uart}, 32'd0);
        check({tag, "_wr"}, {31'b0, wr_uart}, 32'd0);
        check({tag, "_pe"}, {31'b0, pipe_enable}, 32'd0);
        check({tag, "_run"}, {31'b0, running}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_txd"}, {24'b0, tx_data}, 32'd0);
        check({tag, "_cnt"}, cycle_count, 32'd0);
    endtask

    initial begin
        logic [31:0] c0;
        int w0, b0, n;
        bit run_model, ran_in_busy;
        logic [7:0] cmd;

        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("rst_hold");
        reset_n = 1'b1;
        repeat (3) tick();
        check_reset_outputs("rst_rel");

        // Run for about ten cycles, then halt.
        c0 = cycle_count;
        push(C_RUN);
        tick(); tick();
        check("run_set", {31'b0, running}, 32'd1);
        repeat (8) tick();
        push(C_HALT);
        settle(50);
        check("run_clear", {31'b0, running}, 32'd0);
        check("run_cycles_10pm1", {31'b0, (cycle_count - c0) >= 9 && (cycle_count - c0) <= 11}, 32'd1);

        c0 = cycle_count;
        push(8'h41);
        settle(50);
        check("unk_running", {31'b0, running}, 32'd0);
        check("unk_cnt", cycle_count, c0);
        check("unk_busy", {31'b0, busy}, 32'd0);

        // Three single steps while halted.
        c0 = cycle_count;
        mark = 0; pe_mark = 0;
        repeat (3) begin
            push(C_STEP);
            settle(50);
        end
        check("step_pulses", pe_mark, 32'd3);
        check("step_cnt", cycle_count - c0, 32'd3);

        // Step while running is ignored: two enabled cycles from the step pop, not three.
        push(C_RUN);
        settle(50);
        mark = 0; pe_mark = 0;
        push(C_STEP);
        push(C_HALT);
        settle(50);
        check("step_running_pe", pe_mark, 32'd2);
        check("step_running_halt", {31'b0, running}, 32'd0);
        mark = 0;

        // Directed dump, no backpressure.
        snapshot = '0;
        snapshot[31:0] = 32'h11223344;
        build_frame(snapshot);
        check("dump4_csum_model", {24'b0, expq[FRAME-1]}, 32'h44);
        w0 = wr_total; b0 = busy_total;
        push(C_DUMP);
        settle(1000);
        check("dump4_len", wr_total - w0, FRAME);
        check("dump4_busy_cycles", busy_total - b0, FRAME);
        check("dump4_left", expq.size(), 0);

        // Same dump under random backpressure; snapshot scrambled mid-frame; 'c' queued behind.
        full_rand = 1;
        build_frame(snapshot);
        w0 = wr_total;
        ran_in_busy = 0;
        push(C_DUMP);
        push(C_RUN);
        n = 0;
        do begin
            tick();
            n++;
            if (busy) begin
                rand_snapshot();
                if (running) ran_in_busy = 1;
            end
        end while ((rxq.size() != 0 || busy) && n < 3000);
        repeat (2) tick();
        check("dump5_timeout", {31'b0, (rxq.size() != 0 || busy)}, 32'd0);
        check("dump5_run_during", {31'b0, ran_in_busy}, 32'd0);
        check("dump5_run_after", {31'b0, running}, 32'd1);
        check("dump5_len", wr_total - w0, FRAME);
        check("dump5_left", expq.size(), 0);
        push(C_HALT);
        settle(100);

        // Random command mix against the reference model.
        run_model = 0;
        for (int i = 0; i < 10; i++) begin
            full_rand = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 4))
                0: cmd = C_RUN;
                1: cmd = C_HALT;
                2: cmd = C_STEP;
                3: cmd = C_DUMP;
                default: cmd = 8'($urandom_range(0, 255));
            endcase
            if (cmd == C_RUN) run_model = 1;
            if (cmd == C_HALT) run_model = 0;
            if (cmd == C_DUMP) begin
                rand_snapshot();
                build_frame(snapshot);
            end
            push(cmd);
            settle(3000);
            check("rand_running", {31'b0, running}, {31'b0, run_model});
            check("rand_left", expq.size(), 0);
        end
        full_rand = 0;
        push(C_HALT);
        settle(100);

        // Reset in the middle of the payload, then a fresh full frame.
        rand_snapshot();
        build_frame(snapshot);
        w0 = wr_total;
        push(C_DUMP);
        n = 0;
        while (wr_total - w0 < 51 && n < 1000) begin
            tick();
            n++;
        end
        check("rst6_reach_byte50", {31'b0, (wr_total - w0) >= 51}, 32'd1);
        reset_n = 1'b0;
        #1;
        expq.delete();
        check_reset_outputs("rst6");
        tick(); tick();
        reset_n = 1'b1;
        tick();
        rand_snapshot();
        build_frame(snapshot);
        w0 = wr_total;
        push(C_DUMP);
        settle(1000);
        check("rst6_fresh_len", wr_total - w0, FRAME);
        check("end_left", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
